// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : mem_pkg
//  Brief     : Load/store encodings, FSM states and byte-lane helpers shared
//              by the memory-access stage.
//  Revision  : 1.0
// ============================================================================
package mem_pkg;

   typedef enum logic [2:0] {
      LT_LB  = 3'b000,
      LT_LH  = 3'b001,
      LT_LW  = 3'b010,
      LT_LD  = 3'b011,
      LT_LBU = 3'b100,
      LT_LHU = 3'b101,
      LT_LWU = 3'b110
   } load_type_e;

   typedef enum logic [1:0] {
      ST_SB = 2'b00,
      ST_SH = 2'b01,
      ST_SW = 2'b10,
      ST_SD = 2'b11
   } store_type_e;

   typedef enum logic [1:0] {
      S_IDLE      = 2'b00,
      S_WAIT_RESP = 2'b01,
      S_DONE      = 2'b10
   } mem_state_e;

   localparam logic [7:0] c_strb_byte = 8'h01;
   localparam logic [7:0] c_strb_half = 8'h03;
   localparam logic [7:0] c_strb_word = 8'h0F;
   localparam logic [7:0] c_strb_dbl  = 8'hFF;

   // Access size code: 0 byte, 1 half, 2 word, 3 doubleword.
   function automatic logic [7:0] strobe_base(input logic [1:0] size);
      logic [7:0] strb;
      case (size)
         2'd0:    strb = c_strb_byte;
         2'd1:    strb = c_strb_half;
         2'd2:    strb = c_strb_word;
         default: strb = c_strb_dbl;
      endcase
      return strb;
   endfunction

   function automatic logic [2:0] natural_off(input logic [2:0] off,
                                              input logic [1:0] size);
      logic [2:0] o;
      case (size)
         2'd0:    o = off;
         2'd1:    o = {off[2:1], 1'b0};
         2'd2:    o = {off[2], 2'b00};
         default: o = 3'b000;
      endcase
      return o;
   endfunction

   function automatic logic is_misaligned(input logic [2:0] off,
                                          input logic [1:0] size);
      return natural_off(off, size) != off;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_stage_if.sv
`default_nettype none
// ============================================================================
//  Interface : mem_access_stage_if
//  Brief     : dcache request/response channel between the stage and dcache.
//  Revision  : 1.0
// ============================================================================
interface mem_access_stage_if #(
   parameter int ADDR_WIDTH     = 64,
   parameter int BUS_DATA_WIDTH = 64
);
   logic                        dc_req_valid;
   logic                        dc_req_ready;
   logic                        dc_req_we;
   logic [ADDR_WIDTH-1:0]       dc_req_addr;
   logic [BUS_DATA_WIDTH-1:0]   dc_req_wdata;
   logic [7:0]                  dc_req_wstrb;
   logic                        dc_resp_valid;
   logic [BUS_DATA_WIDTH-1:0]   dc_resp_rdata;

   modport master (
      output dc_req_valid, dc_req_we, dc_req_addr, dc_req_wdata, dc_req_wstrb,
      input  dc_req_ready, dc_resp_valid, dc_resp_rdata
   );

   modport slave (
      input  dc_req_valid, dc_req_we, dc_req_addr, dc_req_wdata, dc_req_wstrb,
      output dc_req_ready, dc_resp_valid, dc_resp_rdata
   );
endinterface
`default_nettype wire

// File: rtl/mem_load_align.sv
`default_nettype none
// ============================================================================
//  Module    : mem_load_align
//  Brief     : Shifts the addressed bytes of a doubleword down to bit 0 and
//              sign/zero-extends them according to the load type.
//  Revision  : 1.0
// ============================================================================
module mem_load_align
   import mem_pkg::*;
(
   input  wire  [63:0] i_rdata,
   input  wire  [2:0]  i_off,
   input  wire  [2:0]  i_load_type,
   output logic [63:0] o_data
);

   logic [63:0] w_shifted;

   assign w_shifted = i_rdata >> {i_off, 3'b000};

   always_comb begin
      o_data = w_shifted;
      case (load_type_e'(i_load_type))
         LT_LB:   o_data = {{56{w_shifted[7]}},  w_shifted[7:0]};
         LT_LH:   o_data = {{48{w_shifted[15]}}, w_shifted[15:0]};
         LT_LW:   o_data = {{32{w_shifted[31]}}, w_shifted[31:0]};
         LT_LBU:  o_data = {56'd0, w_shifted[7:0]};
         LT_LHU:  o_data = {48'd0, w_shifted[15:0]};
         LT_LWU:  o_data = {32'd0, w_shifted[31:0]};
         default: o_data = w_shifted;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module    : mem_access_stage
//  Brief     : RV64 memory-access stage: issues one dcache access per load/
//              store, formats load data, registers the writeback fields.
//              Optional macro MEM_MISALIGN_TRAP_EN flags misaligned accesses.
//  Revision  : 1.0
// ============================================================================
module mem_access_stage
   import mem_pkg::*;
#(
   parameter int BUS_DATA_WIDTH = 64,
   parameter int ADDR_WIDTH     = 64
) (
   input  wire                        clk,
   input  wire                        reset_n,
   input  wire [BUS_DATA_WIDTH-1:0]   inResult,
   input  wire [BUS_DATA_WIDTH-1:0]   inDataReg2,
   input  wire                        inMemRead,
   input  wire                        inMemWrite,
   input  wire [2:0]                  inLoadType,
   input  wire [1:0]                  inStoreType,
   input  wire                        inRegWrite,
   input  wire                        inMemOrReg,
   input  wire                        inEcall,
   input  wire [4:0]                  inDestRegister,
   input  wire [63:0]                 inPc,
   input  wire [63:0]                 inEpc,
   input  wire                        in_stall_from_icache,
   mem_access_stage_if.master         dc,
   output logic                       out_stall_from_dcache,
   output logic [BUS_DATA_WIDTH-1:0]  outResult,
   output logic [BUS_DATA_WIDTH-1:0]  outLoadData,
   output logic                       outRegWrite,
   output logic                       outMemOrReg,
   output logic                       outEcall,
   output logic [4:0]                 outDestRegister,
   output logic [63:0]                outPc,
   output logic [63:0]                outEpc
`ifdef MEM_MISALIGN_TRAP_EN
   ,
   output logic                       out_misaligned
`endif
);

   logic                      w_memop;
   logic                      w_is_store;
   logic                      w_misaligned;
   logic                      w_access;
   logic [1:0]                w_size;
   logic [2:0]                w_off;
   logic                      w_req_valid;
   logic                      w_stall;
   logic                      w_wb_en;
   logic [63:0]               w_fmt_load;
   logic [BUS_DATA_WIDTH-1:0] w_wb_load;
   mem_state_e                r_state;
   mem_state_e                w_state_next;
   logic [BUS_DATA_WIDTH-1:0] r_rdata;

   assign w_memop    = inMemRead | inMemWrite;
   // Read and write together is illegal; the read wins.
   assign w_is_store = inMemWrite & ~inMemRead;
   assign w_size     = w_is_store ? inStoreType : inLoadType[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
   assign w_off        = inResult[2:0];
   assign w_misaligned = w_memop & is_misaligned(inResult[2:0], w_size);
`else
   assign w_off        = natural_off(inResult[2:0], w_size);
   assign w_misaligned = 1'b0;
`endif

   // Held quiet during reset so the abandoned instruction cannot re-request.
   assign w_access = w_memop & ~w_misaligned & reset_n;

   assign dc.dc_req_valid = w_req_valid;
   assign dc.dc_req_we    = w_is_store;
   assign dc.dc_req_addr  = {inResult[ADDR_WIDTH-1:3], 3'b000};
   assign dc.dc_req_wstrb = strobe_base(w_size) << w_off;
   assign dc.dc_req_wdata = inDataReg2 << {w_off, 3'b000};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_rdata <= '0;
      end else begin
         r_state <= w_state_next;
         if (r_state == S_WAIT_RESP && dc.dc_resp_valid) begin
            r_rdata <= dc.dc_resp_rdata;
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_req_valid  = 1'b0;
      w_stall      = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_req_valid = w_access;
            w_stall     = w_access;
            if (w_access && dc.dc_req_ready) begin
               w_state_next = S_WAIT_RESP;
            end
         end
         S_WAIT_RESP: begin
            w_stall = 1'b1;
            if (dc.dc_resp_valid) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            // Stay until the writeback register has actually captured.
            if (!in_stall_from_icache) begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   assign out_stall_from_dcache = w_stall;

   mem_load_align u_load_align (
      .i_rdata     (r_rdata),
      .i_off       (w_off),
      .i_load_type (inLoadType),
      .o_data      (w_fmt_load)
   );

   assign w_wb_load = (r_state == S_DONE && inMemRead) ? w_fmt_load : '0;
   assign w_wb_en   = ~w_stall & ~in_stall_from_icache;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         outResult       <= '0;
         outLoadData     <= '0;
         outRegWrite     <= 1'b0;
         outMemOrReg     <= 1'b0;
         outEcall        <= 1'b0;
         outDestRegister <= '0;
         outPc           <= '0;
         outEpc          <= '0;
      end else if (w_wb_en) begin
         outResult       <= inResult;
         outLoadData     <= w_wb_load;
         outRegWrite     <= inRegWrite & ~w_misaligned;
         outMemOrReg     <= inMemOrReg;
         outEcall        <= inEcall;
         outDestRegister <= inDestRegister;
         outPc           <= inPc;
         outEpc          <= inEpc;
      end
   end

`ifdef MEM_MISALIGN_TRAP_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_misaligned <= 1'b0;
      end else if (w_wb_en) begin
         out_misaligned <= w_misaligned;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module    : tb_mem_access_stage
//  Brief     : Vector-table bench with a dcache responder and scoreboard.
//  Revision  : 1.0
// ============================================================================
module tb_mem_access_stage;
   import mem_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [63:0] inResult, inDataReg2, inPc, inEpc;
   logic        inMemRead, inMemWrite, inRegWrite, inMemOrReg, inEcall;
   logic [2:0]  inLoadType;
   logic [1:0]  inStoreType;
   logic [4:0]  inDestRegister;
   logic        in_stall_from_icache;
   logic        out_stall_from_dcache;
   logic [63:0] outResult, outLoadData, outPc, outEpc;
   logic        outRegWrite, outMemOrReg, outEcall;
   logic [4:0]  outDestRegister;
`ifdef MEM_MISALIGN_TRAP_EN
   logic        out_misaligned;
`endif

   mem_access_stage_if dc ();

   always #5 clk = ~clk;

   mem_access_stage dut (
      .clk                   (clk),
      .reset_n               (reset_n),
      .inResult              (inResult),
      .inDataReg2            (inDataReg2),
      .inMemRead             (inMemRead),
      .inMemWrite            (inMemWrite),
      .inLoadType            (inLoadType),
      .inStoreType           (inStoreType),
      .inRegWrite            (inRegWrite),
      .inMemOrReg            (inMemOrReg),
      .inEcall               (inEcall),
      .inDestRegister        (inDestRegister),
      .inPc                  (inPc),
      .inEpc                 (inEpc),
      .in_stall_from_icache  (in_stall_from_icache),
      .dc                    (dc),
      .out_stall_from_dcache (out_stall_from_dcache),
      .outResult             (outResult),
      .outLoadData           (outLoadData),
      .outRegWrite           (outRegWrite),
      .outMemOrReg           (outMemOrReg),
      .outEcall              (outEcall),
      .outDestRegister       (outDestRegister),
      .outPc                 (outPc),
      .outEpc                (outEpc)
`ifdef MEM_MISALIGN_TRAP_EN
      ,
      .out_misaligned        (out_misaligned)
`endif
   );

   typedef struct {
      logic [63:0] result, data2, pc, epc, rdata;
      logic        rd, wr, regw, mor, ecall;
      logic [2:0]  lt;
      logic [1:0]  st;
      logic [4:0]  dest;
      int          ready_dly, icache;
      int          exp_stall, exp_req, exp_cyc;
      logic [63:0] exp_addr, exp_wdata, exp_load;
      logic        exp_we, exp_regw, exp_mis;
      logic [7:0]  exp_strb;
   } vec_t;

   typedef struct {
      logic [63:0] result, load, pc, epc;
      logic        regw, mor, ecall, mis;
      logic [4:0]  dest;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   function automatic vec_t mk_alu(input logic [63:0] res, input logic [4:0] dest,
                                   input logic ecall);
      vec_t v = '{default: '0};
      v.result = res; v.dest = dest; v.ecall = ecall; v.regw = ~ecall;
      v.mor = 1'b0; v.pc = 64'h8000_0000 + res; v.epc = ecall ? v.pc : 64'h0;
      v.exp_cyc = 1; v.exp_regw = ~ecall;
      return v;
   endfunction

   function automatic vec_t mk_load(input logic [63:0] addr, input logic [2:0] lt,
                                    input logic [63:0] rdata, input logic [63:0] expd,
                                    input int rdy, input int ic);
      vec_t v = '{default: '0};
      v.result = addr; v.rd = 1'b1; v.lt = lt; v.rdata = rdata; v.regw = 1'b1;
      v.mor = 1'b1; v.dest = 5'd10; v.pc = 64'h8000_0000 + addr; v.epc = 64'h44;
      v.ready_dly = rdy; v.icache = ic;
      v.exp_req = 1; v.exp_stall = rdy + 2; v.exp_cyc = rdy + 3 + ic;
      v.exp_addr = {addr[63:3], 3'b000}; v.exp_load = expd; v.exp_regw = 1'b1;
      return v;
   endfunction

   function automatic vec_t mk_store(input logic [63:0] addr, input logic [1:0] st,
                                     input logic [63:0] data, input logic [7:0] strb,
                                     input logic [63:0] wdata);
      vec_t v = '{default: '0};
      v.result = addr; v.wr = 1'b1; v.st = st; v.data2 = data;
      v.rdata = 64'hFFFF_FFFF_FFFF_FFFF; v.dest = 5'd3; v.pc = 64'h9000_0000 + addr;
      v.exp_req = 1; v.exp_stall = 2; v.exp_cyc = 3; v.exp_addr = {addr[63:3], 3'b000};
      v.exp_we = 1'b1; v.exp_strb = strb; v.exp_wdata = wdata;
      return v;
   endfunction

   task automatic run_vec(input vec_t v);
      exp_t e;
      int   stall_cnt, req_cnt, cyc, rdy_left, ic_left;
      bit   accepted, accepted_ever, resp_now, ic_on, capture;
      e.result = v.result; e.load = v.exp_load; e.pc = v.pc; e.epc = v.epc;
      e.regw = v.exp_regw; e.mor = v.mor; e.ecall = v.ecall; e.mis = v.exp_mis;
      e.dest = v.dest;
      sb.push_back(e);
      inResult = v.result; inDataReg2 = v.data2; inMemRead = v.rd; inMemWrite = v.wr;
      inLoadType = v.lt; inStoreType = v.st; inRegWrite = v.regw; inMemOrReg = v.mor;
      inEcall = v.ecall; inDestRegister = v.dest; inPc = v.pc; inEpc = v.epc;
      in_stall_from_icache = 1'b0;
      dc.dc_resp_valid = 1'b0;
      rdy_left = v.ready_dly;
      dc.dc_req_ready = (rdy_left == 0);
      stall_cnt = 0; req_cnt = 0; cyc = 0; ic_left = v.icache;
      accepted_ever = 0; ic_on = 0; capture = 0;
      while (!capture && cyc < 60) begin
         #1;
         if (out_stall_from_dcache) stall_cnt++;
         accepted = dc.dc_req_valid && dc.dc_req_ready;
         if (accepted) begin
            req_cnt++;
            if (req_cnt == 1) begin
               chk("req_addr", dc.dc_req_addr, v.exp_addr);
               chk("req_we", dc.dc_req_we, v.exp_we);
               if (v.exp_we) begin
                  chk("req_wstrb", dc.dc_req_wstrb, v.exp_strb);
                  chk("req_wdata", dc.dc_req_wdata, v.exp_wdata);
               end
            end
         end
         resp_now = dc.dc_resp_valid;
         capture  = !out_stall_from_dcache && !in_stall_from_icache;
         @(posedge clk);
         @(negedge clk);
         cyc++;
         // Responder: answer exactly one cycle after the request is accepted.
         dc.dc_resp_valid = accepted;
         dc.dc_resp_rdata = v.rdata;
         if (accepted) accepted_ever = 1;
         if (!accepted_ever && rdy_left > 0) rdy_left--;
         dc.dc_req_ready = !accepted_ever && (rdy_left == 0);
         if (resp_now) ic_on = 1;
         if (ic_on && ic_left > 0) begin
            in_stall_from_icache = 1'b1;
            ic_left--;
         end else begin
            in_stall_from_icache = 1'b0;
         end
      end
      chk("captured", capture, 1);
      #1;
      e = sb.pop_front();
      chk("stall_cycles", stall_cnt, v.exp_stall);
      chk("req_count", req_cnt, v.exp_req);
      chk("latency", cyc, v.exp_cyc);
      chk("outResult", outResult, e.result);
      chk("outLoadData", outLoadData, e.load);
      chk("outRegWrite", outRegWrite, e.regw);
      chk("outMemOrReg", outMemOrReg, e.mor);
      chk("outEcall", outEcall, e.ecall);
      chk("outDestRegister", outDestRegister, e.dest);
      chk("outPc", outPc, e.pc);
      chk("outEpc", outEpc, e.epc);
`ifdef MEM_MISALIGN_TRAP_EN
      chk("out_misaligned", out_misaligned, e.mis);
`endif
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_outResult"}, outResult, 64'h0);
      chk({tag, "_outLoadData"}, outLoadData, 64'h0);
      chk({tag, "_outRegWrite"}, outRegWrite, 0);
      chk({tag, "_outDest"}, outDestRegister, 0);
      chk({tag, "_outPc"}, outPc, 64'h0);
      chk({tag, "_outEpc"}, outEpc, 64'h0);
      chk({tag, "_stall"}, out_stall_from_dcache, 0);
      chk({tag, "_req_valid"}, dc.dc_req_valid, 0);
   endtask

   initial begin
      vec_t v;
      reset_n = 1'b0;
      inResult = '0; inDataReg2 = '0; inMemRead = 0; inMemWrite = 0; inLoadType = '0;
      inStoreType = '0; inRegWrite = 0; inMemOrReg = 0; inEcall = 0; inDestRegister = '0;
      inPc = '0; inEpc = '0; in_stall_from_icache = 0;
      dc.dc_req_ready = 0; dc.dc_resp_valid = 0; dc.dc_resp_rdata = '0;

      vecs.push_back(mk_alu(64'h1234, 5'd5, 1'b0));
      vecs.push_back(mk_load(64'h1000, LT_LD, 64'h8877665544332211, 64'h8877665544332211, 0, 0));
      vecs.push_back(mk_load(64'h1003, LT_LB, 64'h1122334480556677, 64'hFFFFFFFFFFFFFF80, 0, 0));
      vecs.push_back(mk_load(64'h1003, LT_LBU, 64'h1122334480556677, 64'h80, 0, 0));
      vecs.push_back(mk_store(64'h1006, ST_SH, 64'hBEEF, 8'hC0, 64'hBEEF000000000000));
      vecs.push_back(mk_load(64'h100A, LT_LH, 64'h0000000080010000, 64'hFFFFFFFFFFFF8001, 0, 0));
      vecs.push_back(mk_load(64'h100A, LT_LHU, 64'h0000000080010000, 64'h8001, 0, 0));
      vecs.push_back(mk_load(64'h1004, LT_LW, 64'h8765432100000000, 64'hFFFFFFFF87654321, 0, 0));
      vecs.push_back(mk_load(64'h1004, LT_LWU, 64'h8765432100000000, 64'h87654321, 0, 0));
      vecs.push_back(mk_store(64'h1005, ST_SB, 64'h123456789ABCDEAB, 8'h20, 64'hBCDEAB0000000000));
      vecs.push_back(mk_store(64'h1004, ST_SW, 64'hCAFEBABE, 8'hF0, 64'hCAFEBABE00000000));
      vecs.push_back(mk_store(64'h1008, ST_SD, 64'h0123456789ABCDEF, 8'hFF, 64'h0123456789ABCDEF));
      vecs.push_back(mk_load(64'h2000, LT_LD, 64'hDEADBEEF01234567, 64'hDEADBEEF01234567, 3, 2));
      v = mk_load(64'h1001, LT_LBU, 64'h000000000000AA00, 64'hAA, 0, 0);
      v.wr = 1'b1;
      vecs.push_back(v);
      vecs.push_back(mk_alu(64'h0, 5'd0, 1'b1));
`ifdef MEM_MISALIGN_TRAP_EN
      v = mk_load(64'h1002, LT_LW, 64'h000000007FFF1234, 64'h0, 0, 0);
      v.exp_req = 0; v.exp_stall = 0; v.exp_cyc = 1; v.exp_regw = 1'b0; v.exp_mis = 1'b1;
      vecs.push_back(v);
      v = mk_store(64'h1007, ST_SH, 64'h1234, 8'h00, 64'h0);
      v.exp_req = 0; v.exp_stall = 0; v.exp_cyc = 1; v.exp_mis = 1'b1;
      vecs.push_back(v);
`else
      vecs.push_back(mk_load(64'h1002, LT_LW, 64'h000000007FFF1234, 64'h7FFF1234, 0, 0));
      vecs.push_back(mk_store(64'h1007, ST_SH, 64'h1234, 8'hC0, 64'h1234000000000000));
`endif
      vecs.push_back(mk_alu(64'hFFFF_0000_1111_2222, 5'd31, 1'b0));

      repeat (3) @(negedge clk);
      #1;
      chk_reset_outputs("reset");
      reset_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);
      chk("sb_empty", sb.size(), 0);

      // Reset while the access is outstanding.
      inResult = 64'h3000; inMemRead = 1; inMemWrite = 0; inLoadType = LT_LD;
      inRegWrite = 1; inDestRegister = 5'd7; inPc = 64'h3333; dc.dc_req_ready = 1;
      @(posedge clk);
      @(negedge clk);
      dc.dc_req_ready = 0;
      #1;
      chk("wait_stall", out_stall_from_dcache, 1);
      chk("wait_req_valid", dc.dc_req_valid, 0);
      reset_n = 1'b0;
      #1;
      chk_reset_outputs("midreset");
      inMemRead = 0; inRegWrite = 0; inDestRegister = '0; inPc = '0;
      @(negedge clk);
      reset_n = 1'b1;
      run_vec(mk_alu(64'h5A5A, 5'd9, 1'b0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
